// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds the FSM state encoding, the opcodes the controller decodes, and the
// encodings of the multi-bit mux selects driven towards the datapath.
package multi_cycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_R   = 4'd8,
    S_WB_I   = 4'd9,
    S_WB_MEM = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  // Opcodes (Ins[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // ALUOp
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_OR    = 2'd3;

  // PCSrc
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // ALUSrcB
  localparam logic [1:0] SRCB_RDATA2 = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // RegDst
  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  // MemtoReg
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEMD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational opcode decoder used in the DECODE state.
// Ports:
//   Op         - instruction opcode field
//   next_o     - state to enter after DECODE
//   illegal_o  - opcode is neither a supported instruction nor HALT_OP
//   exec_alu_o - ALUOp to use in EXEC_I (add for addi, or for ori)
module multi_cycle_ctrl_decode
  import multi_cycle_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic [5:0] Op,
  output state_e     next_o,
  output logic       illegal_o,
  output logic [1:0] exec_alu_o
);

  always_comb begin
    next_o    = S_HALT;
    illegal_o = 1'b0;
    case (Op)
      OP_RTYPE:        next_o = S_EXEC_R;
      OP_LW, OP_SW:    next_o = S_ADDR;
      OP_BEQ, OP_BNE:  next_o = S_BRANCH;
      OP_J, OP_JAL:    next_o = S_JUMP;
      OP_ADDI, OP_ORI: next_o = S_EXEC_I;
      default: begin
        // Anything unknown parks the machine in HALT; only a genuine
        // HALT_OP leaves the sticky illegal flag clear.
        next_o    = S_HALT;
        illegal_o = (Op != HALT_OP);
      end
    endcase
  end

  assign exec_alu_o = (Op == OP_ORI) ? ALU_OR : ALU_ADD;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM. Steps one instruction at a time through
// fetch, decode, execute, memory and write-back, driving the datapath
// enables and mux selects, waiting on MemRdy for memory accesses, and
// counting retired instructions.
// Ports:
//   CLK, RST          - clock, synchronous active-high reset
//   Run               - start request, honoured only in IDLE
//   Op, Funct, Zero   - instruction fields and ALU zero flag
//   MemRdy            - completes the current memory access
//   IorD..RegWrite    - datapath controls (Moore, except FETCH handshake
//                       enables and the conditional PCEn in BRANCH)
//   Busy              - executing (not IDLE / HALT)
//   Illegal           - sticky unsupported-opcode flag
//   InsCount          - retired instruction counter (wraps)
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Run,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemRdy,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCEn,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             Busy,
  output logic             Illegal,
  output logic [CNT_W-1:0] InsCount
);

  state_e             state_q, state_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire;

  state_e             dec_next;
  logic               dec_illegal;
  logic [1:0]         dec_exec_alu;

  // Funct is consumed by the separate ALU control block (ALUOp=2).
  logic               unused_funct;
  assign unused_funct = ^Funct;

  multi_cycle_ctrl_decode #(
    .HALT_OP (HALT_OP)
  ) u_decode (
    .Op         (Op),
    .next_o     (dec_next),
    .illegal_o  (dec_illegal),
    .exec_alu_o (dec_exec_alu)
  );

  // Next state, sticky flag and retirement
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:   if (Run) state_d = S_FETCH;
      S_FETCH:  if (MemRdy) state_d = S_DECODE;
      S_DECODE: begin
        state_d = dec_next;
        if (dec_illegal) illegal_d = 1'b1;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_ADDR:   state_d = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (MemRdy) state_d = S_WB_MEM;
      S_MEM_WR: begin
        if (MemRdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Datapath controls
  always_comb begin
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCEn     = 1'b0;
    PCSrc    = PC_PLUS4;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RDATA2;
    ALUOp    = ALU_ADD;
    RegDst   = DST_RT;
    MemtoReg = WB_ALU;
    RegWrite = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // IR load and PC+4 update land on the cycle the fetch completes.
        IRWrite = MemRdy;
        PCEn    = MemRdy;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = dec_exec_alu;
      end
      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_WB_R: begin
        RegDst   = DST_RD;
        RegWrite = 1'b1;
      end
      S_WB_I: RegWrite = 1'b1;
      S_WB_MEM: begin
        MemtoReg = WB_MEMD;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SUB;
        PCSrc   = PC_BRANCH;
        PCEn    = (Op == OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCSrc = PC_JUMP;
        PCEn  = 1'b1;
        if (Op == OP_JAL) begin
          RegDst   = DST_R31;
          MemtoReg = WB_PC4;
          RegWrite = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign Busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign Illegal  = illegal_q;
  assign InsCount = cnt_q;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: fixed vectors, hand-written corner sequences
// and random instruction streams checked against a per-instruction model.
module tb_multi_cycle_ctrl;

  localparam int         CNT_W   = 4;
  localparam logic [5:0] HALT_OP = 6'b111111;

  localparam logic [5:0] I_R    = 6'b000000;
  localparam logic [5:0] I_LW   = 6'b100011;
  localparam logic [5:0] I_SW   = 6'b101011;
  localparam logic [5:0] I_BEQ  = 6'b000100;
  localparam logic [5:0] I_BNE  = 6'b000101;
  localparam logic [5:0] I_J    = 6'b000010;
  localparam logic [5:0] I_JAL  = 6'b000011;
  localparam logic [5:0] I_ADDI = 6'b001000;
  localparam logic [5:0] I_ORI  = 6'b001101;

  logic             CLK, RST, Run, Zero, MemRdy;
  logic [5:0]       Op, Funct;
  logic             IorD, MemRead, MemWrite, IRWrite, PCEn, ALUSrcA, RegWrite, Busy, Illegal;
  logic [1:0]       PCSrc, ALUSrcB, ALUOp, RegDst, MemtoReg;
  logic [CNT_W-1:0] InsCount;

  multi_cycle_ctrl #(.CNT_W(CNT_W), .HALT_OP(HALT_OP)) dut (
    .CLK(CLK), .RST(RST), .Run(Run), .Op(Op), .Funct(Funct), .Zero(Zero),
    .MemRdy(MemRdy), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .Busy(Busy), .Illegal(Illegal), .InsCount(InsCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int cyc; int rw; int rw_at; int pcen; int mwc; int mrc; int irw;
    int busy_bad; int rd; int m2r; int alui; int pcsrc; int to;
  } res_t;

  typedef struct {
    logic [5:0] op; bit z; int fw; int mw;
    int cyc; int rw; int pcen; int mwc; int mrc; int rd; int m2r; int alui; int pcsrc;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    check({tag, " timeout"},  a.to,       e.to);
    check({tag, " cycles"},   a.cyc,      e.cyc);
    check({tag, " regwr"},    a.rw,       e.rw);
    check({tag, " regwr_at"}, a.rw_at,    e.rw_at);
    check({tag, " pcen"},     a.pcen,     e.pcen);
    check({tag, " memwr"},    a.mwc,      e.mwc);
    check({tag, " memrd"},    a.mrc,      e.mrc);
    check({tag, " irwrite"},  a.irw,      e.irw);
    check({tag, " busy"},     a.busy_bad, e.busy_bad);
    check({tag, " regdst"},   a.rd,       e.rd);
    check({tag, " memtoreg"}, a.m2r,      e.m2r);
    check({tag, " aluop_i"},  a.alui,     e.alui);
    check({tag, " pcsrc"},    a.pcsrc,    e.pcsrc);
  endtask

  // Per-instruction cost and side effects from the instruction-level rules.
  function automatic res_t model(input logic [5:0] op, input bit z, input int fw, input int mw);
    res_t e;
    bit taken;
    e = '{cyc:0, rw:0, rw_at:-1, pcen:1, mwc:0, mrc:fw + 1, irw:1,
          busy_bad:0, rd:-1, m2r:-1, alui:-1, pcsrc:-1, to:0};
    case (op)
      I_R:    begin e.cyc = 4; e.rw = 1; e.rd = 1; e.m2r = 0; end
      I_ADDI: begin e.cyc = 4; e.rw = 1; e.rd = 0; e.m2r = 0; e.alui = 0; end
      I_ORI:  begin e.cyc = 4; e.rw = 1; e.rd = 0; e.m2r = 0; e.alui = 3; end
      I_LW:   begin e.cyc = 5 + mw; e.rw = 1; e.rd = 0; e.m2r = 1; e.alui = 0; e.mrc += mw + 1; end
      I_SW:   begin e.cyc = 4 + mw; e.mwc = mw + 1; e.alui = 0; end
      I_BEQ, I_BNE: begin
        e.cyc = 3;
        taken = ((op == I_BEQ) == z);
        if (taken) begin e.pcen++; e.pcsrc = 1; end
      end
      I_J:    begin e.cyc = 3; e.pcen++; e.pcsrc = 2; end
      I_JAL:  begin e.cyc = 3; e.pcen++; e.pcsrc = 2; e.rw = 1; e.rd = 2; e.m2r = 2; end
      default: ;
    endcase
    e.cyc += fw;
    if (e.rw != 0) e.rw_at = e.cyc;
    return e;
  endfunction

  // Entered at a negedge with the DUT in FETCH. Plays memory with fw/mw
  // wait cycles and observes until InsCount moves (next FETCH reached).
  task automatic run_instr(input logic [5:0] op, input bit z, input int fw, input int mw,
                           output res_t r);
    logic [CNT_W-1:0] c0;
    int fcnt, mcnt;
    c0 = InsCount; fcnt = 0; mcnt = 0;
    r = '{cyc:0, rw:0, rw_at:-1, pcen:0, mwc:0, mrc:0, irw:0,
          busy_bad:0, rd:-1, m2r:-1, alui:-1, pcsrc:-1, to:0};
    Op = op; Zero = z; Funct = 6'($urandom_range(0, 63));
    forever begin
      if (InsCount != c0) break;
      if (r.cyc >= 200) begin r.to = 1; break; end
      if (MemRead && !IorD) begin
        MemRdy = (fcnt == fw); fcnt++;
      end else if ((MemRead || MemWrite) && IorD) begin
        MemRdy = (mcnt == mw); mcnt++;
      end else begin
        MemRdy = 1'($urandom_range(0, 1));
      end
      #1;
      r.cyc++;
      if (RegWrite) begin r.rw++; r.rw_at = r.cyc; r.rd = RegDst; r.m2r = MemtoReg; end
      r.mwc  += int'(MemWrite);
      r.mrc  += int'(MemRead);
      r.pcen += int'(PCEn);
      r.irw  += int'(IRWrite);
      if (!Busy) r.busy_bad++;
      if (ALUSrcA && ALUSrcB == 2'd2) r.alui = ALUOp;
      if (PCEn && !MemRead) r.pcsrc = PCSrc;
      @(negedge CLK);
    end
  endtask

  vec_t tbl[12];
  logic [5:0] pool[9];
  res_t r, e;
  logic [CNT_W-1:0] exp_cnt;
  logic [5:0] rop;
  bit rz;
  int rfw, rmw;

  initial begin
    tbl[0]  = '{I_R,    1'b0, 0, 0, 4, 1, 1, 0, 1,  1,  0, -1, -1};
    tbl[1]  = '{I_LW,   1'b0, 0, 3, 8, 1, 1, 0, 5,  0,  1,  0, -1};
    tbl[2]  = '{I_BEQ,  1'b1, 0, 0, 3, 0, 2, 0, 1, -1, -1, -1,  1};
    tbl[3]  = '{I_BEQ,  1'b0, 0, 0, 3, 0, 1, 0, 1, -1, -1, -1, -1};
    tbl[4]  = '{I_BNE,  1'b1, 0, 0, 3, 0, 1, 0, 1, -1, -1, -1, -1};
    tbl[5]  = '{I_BNE,  1'b0, 0, 0, 3, 0, 2, 0, 1, -1, -1, -1,  1};
    tbl[6]  = '{I_JAL,  1'b0, 0, 0, 3, 1, 2, 0, 1,  2,  2, -1,  2};
    tbl[7]  = '{I_J,    1'b1, 0, 0, 3, 0, 2, 0, 1, -1, -1, -1,  2};
    tbl[8]  = '{I_ADDI, 1'b0, 2, 0, 6, 1, 1, 0, 3,  0,  0,  0, -1};
    tbl[9]  = '{I_ORI,  1'b0, 0, 0, 4, 1, 1, 0, 1,  0,  0,  3, -1};
    tbl[10] = '{I_SW,   1'b0, 0, 2, 6, 0, 1, 3, 1, -1, -1,  0, -1};
    tbl[11] = '{I_LW,   1'b1, 1, 0, 6, 1, 1, 0, 3,  0,  1,  0, -1};
    pool = '{I_R, I_LW, I_SW, I_BEQ, I_BNE, I_J, I_JAL, I_ADDI, I_ORI};

    RST = 1'b1; Run = 1'b0; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; MemRdy = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset outputs",
          int'({IorD, MemRead, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                ALUOp, RegDst, MemtoReg, RegWrite, Busy}), 0);
    check("reset Illegal", Illegal, 0);
    check("reset InsCount", InsCount, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle without Run", MemRead, 0);

    Run = 1'b1;
    @(negedge CLK);
    Run = 1'b0;
    check("fetch after Run", MemRead && Busy, 1);
    exp_cnt = '0;

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw, r);
      e = '{cyc:tbl[i].cyc, rw:tbl[i].rw, rw_at:(tbl[i].rw != 0) ? tbl[i].cyc : -1,
            pcen:tbl[i].pcen, mwc:tbl[i].mwc, mrc:tbl[i].mrc, irw:1, busy_bad:0,
            rd:tbl[i].rd, m2r:tbl[i].m2r, alui:tbl[i].alui, pcsrc:tbl[i].pcsrc, to:0};
      cmp_res($sformatf("vec%0d", i), r, e);
      exp_cnt = exp_cnt + 1'b1;
      check($sformatf("vec%0d InsCount", i), InsCount, exp_cnt);
    end

    for (int i = 0; i < 40; i++) begin
      rop = pool[$urandom_range(0, 8)];
      rz  = 1'($urandom_range(0, 1));
      rfw = $urandom_range(0, 3);
      rmw = $urandom_range(0, 3);
      run_instr(rop, rz, rfw, rmw, r);
      cmp_res($sformatf("rnd%0d op=%b", i, rop), r, model(rop, rz, rfw, rmw));
      exp_cnt = exp_cnt + 1'b1;
      check($sformatf("rnd%0d InsCount", i), InsCount, exp_cnt);
    end
    check("no Illegal on legal stream", Illegal, 0);

    // HALT_OP: halts without counting or flagging; Run is ignored
    Op = HALT_OP; MemRdy = 1'b1;
    repeat (2) @(negedge CLK);
    check("halt Busy", Busy, 0);
    check("halt Illegal", Illegal, 0);
    check("halt InsCount", InsCount, exp_cnt);
    Run = 1'b1;
    repeat (2) @(negedge CLK);
    Run = 1'b0;
    check("halt ignores Run", {Busy, MemRead}, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("reset from halt InsCount", InsCount, 0);

    // Illegal opcode
    Run = 1'b1;
    @(negedge CLK);
    Run = 1'b0;
    check("restart fetch", MemRead, 1);
    Op = 6'b010101; MemRdy = 1'b1;
    repeat (2) @(negedge CLK);
    check("illegal flag", Illegal, 1);
    check("illegal halts", Busy, 0);
    for (int k = 0; k < 3; k++) begin
      Run = 1'b1; @(negedge CLK); Run = 1'b0; @(negedge CLK);
    end
    check("illegal sticky", Illegal, 1);
    check("illegal ignores Run", {Busy, MemRead}, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("reset clears Illegal", Illegal, 0);
    Run = 1'b1;
    @(negedge CLK);
    Run = 1'b0;
    check("idle after reset accepts Run", MemRead, 1);

    // Reset while a store is waiting on memory
    run_instr(I_R, 1'b0, 0, 0, r);
    check("pre-abort InsCount", InsCount, 1);
    Op = I_SW; MemRdy = 1'b1;
    @(negedge CLK);
    MemRdy = 1'b0;
    repeat (2) @(negedge CLK);
    check("in MEM_WR", {MemWrite, IorD}, 3);
    RST = 1'b1;
    @(negedge CLK);
    check("abort MemWrite", MemWrite, 0);
    check("abort RegWrite", RegWrite, 0);
    check("abort Busy", Busy, 0);
    check("abort InsCount", InsCount, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("abort stays idle", MemRead, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
